// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith/shift ops plus iterative unsigned
// MULT/DIV into HI/LO, with a start/busy/done handshake for datapath stalls.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [4:0]       alu_shamt,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_zero,
  output logic [WIDTH-1:0] alu_hi,
  output logic [WIDTH-1:0] alu_lo,
  output logic             alu_busy,
  output logic             alu_done,
  output logic             alu_div_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             last_step;
  logic             long_op;

  logic [WIDTH-1:0] work_hi_q, work_lo_q, opnd_b_q;
  logic             is_div_q;
  logic             b_zero;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [4:0]       sh);
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b1010: r = a ^ b;
      4'b0111: r = (sa < sb) ? WIDTH'(1) : '0;
      4'b1100: r = b << sh;
      4'b1101: r = b >> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept    = alu_start && (state_q == IDLE);
  assign long_op   = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign alu_busy  = (state_q == MUL) || (state_q == DIV);
  assign b_zero    = (opnd_b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= accept ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && alu_op == OP_MULT)     state_d = MUL;
            else if (accept && alu_op == OP_DIV) state_d = DIV;
      MUL:  if (last_step) state_d = FIN;
      DIV:  if (last_step) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Iteration step: multiplier/dividend shifts through work_lo, partial sums in work_hi
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_b_q} : '0);
    div_trial = {work_hi_q, work_lo_q[WIDTH-1]} - {1'b0, opnd_b_q};
    fin_hi    = work_hi_q;
    fin_lo    = work_lo_q;
    if (is_div_q && b_zero) begin
      fin_hi = work_lo_q;
      fin_lo = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      work_hi_q <= '0;
      work_lo_q <= alu_a;
      opnd_b_q  <= alu_b;
      is_div_q  <= (alu_op == OP_DIV);
    end else if (state_q == MUL) begin
      work_hi_q <= mul_sum[WIDTH:1];
      work_lo_q <= {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end else if (state_q == DIV && !b_zero) begin
      // Divide-by-zero leaves the dividend parked in work_lo for the remainder
      if (!div_trial[WIDTH]) begin
        work_hi_q <= div_trial[WIDTH-1:0];
        work_lo_q <= {work_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        work_hi_q <= {work_hi_q[WIDTH-2:0], work_lo_q[WIDTH-1]};
        work_lo_q <= {work_lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result   <= '0;
      alu_zero     <= 1'b0;
      alu_hi       <= '0;
      alu_lo       <= '0;
      alu_done     <= 1'b0;
      alu_div_zero <= 1'b0;
    end else begin
      alu_done <= 1'b0;
      if (accept) begin
        alu_div_zero <= 1'b0;
        if (!long_op) begin
          alu_result <= single_op(alu_op, alu_a, alu_b, alu_shamt);
          alu_zero   <= (single_op(alu_op, alu_a, alu_b, alu_shamt) == '0);
          alu_done   <= 1'b1;
        end
      end else if (state_q == FIN) begin
        alu_hi       <= fin_hi;
        alu_lo       <= fin_lo;
        alu_result   <= fin_lo;
        alu_zero     <= (fin_lo == '0);
        alu_done     <= 1'b1;
        alu_div_zero <= is_div_q && b_zero;
      end
    end
  end

endmodule
